// File: rtl/issue_buffer_if.sv
// Decoded-instruction record shared by decode, the issue buffer and issue/EX,
// plus the bundle of decode/back-end signals that surround the issue buffer.
package issue_buffer_pkg;
  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [9:0]  inst_type;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        mem_we;
    logic [3:0]  ldst_type;
  } PC_set;
endpackage

interface issue_buffer_if #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
);
  import issue_buffer_pkg::*;

  logic           flush_BR;
  logic           stall_DCache;
  logic           stall_div;
  PC_set          d_set1;
  PC_set          d_set2;
  logic           in_ready;
  PC_set          i_set1;
  PC_set          i_set2;
  logic [4:0]     rf_raddr_a1;
  logic [4:0]     rf_raddr_a2;
  logic [4:0]     rf_raddr_b1;
  logic [4:0]     rf_raddr_b2;
  logic [PTR_W:0] count;
  logic           empty;

  modport master (
    output flush_BR, stall_DCache, stall_div, d_set1, d_set2,
    input  in_ready, i_set1, i_set2, rf_raddr_a1, rf_raddr_a2,
           rf_raddr_b1, rf_raddr_b2, count, empty
  );

  modport slave (
    input  flush_BR, stall_DCache, stall_div, d_set1, d_set2,
    output in_ready, i_set1, i_set2, rf_raddr_a1, rf_raddr_a2,
           rf_raddr_b1, rf_raddr_b2, count, empty
  );
endinterface

// File: rtl/issue_buffer.sv
// Dual-issue circular instruction queue: accepts up to two decoded entries per
// cycle, presents the two oldest with pairing decision and regfile addresses.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  issue_buffer_if.slave bus
);

  localparam logic [9:0] TYPE_ALU  = 10'h001;
  localparam logic [9:0] TYPE_ERTN = 10'h020;

  PC_set          mem_q [DEPTH];
  PC_set          mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  PC_set      e1, e2;
  logic       in_ready;
  logic       push_ok;
  logic [1:0] npush, npop;
  logic       v1, v2, ov1, ov2;
  logic       pair_ok;
  logic       stall;

  assign e1 = mem_q[head_q];
  assign e2 = mem_q[head_q + PTR_W'(1)];

  // Uses the registered count only; a pop in this cycle does not free space yet.
  assign in_ready = (count_q <= (PTR_W+1)'(DEPTH - 2));
  assign push_ok  = in_ready & ~bus.flush_BR;
  assign stall    = bus.stall_DCache | bus.stall_div;

  always_comb begin
    pair_ok = 1'b1;
    if ((e1.inst_type != TYPE_ALU) && (e2.inst_type != TYPE_ALU))
      pair_ok = 1'b0;
    if ((e1.inst_type == TYPE_ERTN) || (e2.inst_type == TYPE_ERTN))
      pair_ok = 1'b0;
    if (e1.rf_we && (e1.rf_rd != 5'd0) &&
        ((e1.rf_rd == e2.rf_raddr1) || (e1.rf_rd == e2.rf_raddr2)))
      pair_ok = 1'b0;
    if (e1.rf_we && e2.rf_we && (e1.rf_rd == e2.rf_rd) && (e1.rf_rd != 5'd0))
      pair_ok = 1'b0;
    if ((e1.mem_we || (e1.ldst_type != 4'd0)) && (e2.mem_we || (e2.ldst_type != 4'd0)))
      pair_ok = 1'b0;
  end

  always_comb begin
    v1   = (count_q >= (PTR_W+1)'(1));
    v2   = (count_q >= (PTR_W+1)'(2)) && pair_ok;
    ov1  = v1 & ~bus.flush_BR;
    ov2  = v2 & ~bus.flush_BR;
    npop = stall ? 2'd0 : ({1'b0, ov1} + {1'b0, ov2});
  end

  // Valid inputs are compacted at tail: a lone d_set2 lands at tail itself.
  always_comb begin
    mem_d = mem_q;
    npush = 2'd0;
    if (push_ok) begin
      if (bus.d_set1.o_valid)
        mem_d[tail_q] = bus.d_set1;
      if (bus.d_set2.o_valid)
        mem_d[tail_q + PTR_W'(bus.d_set1.o_valid)] = bus.d_set2;
      npush = {1'b0, bus.d_set1.o_valid} + {1'b0, bus.d_set2.o_valid};
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(npop);
    tail_d  = tail_q + PTR_W'(npush);
    count_d = count_q + (PTR_W+1)'(npush) - (PTR_W+1)'(npop);
    if (bus.flush_BR) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.i_set1         = e1;
    bus.i_set1.o_valid = ov1;
    bus.i_set2         = e2;
    bus.i_set2.o_valid = ov2;
  end

  assign bus.in_ready    = in_ready;
  assign bus.rf_raddr_a1 = e1.rf_raddr1;
  assign bus.rf_raddr_a2 = e1.rf_raddr2;
  assign bus.rf_raddr_b1 = e2.rf_raddr1;
  assign bus.rf_raddr_b2 = e2.rf_raddr2;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);

endmodule
